// File: rtl/ahb_fir_pkg.sv
// Shared types and constants for the AHB FIR sample-path blocks.
package ahb_fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fir_seq_state_t;

    // fir_seq_ctrl register addresses (haddr[1:0])
    localparam logic [1:0] FIR_SEQ_CTRL_A   = 2'd0;
    localparam logic [1:0] FIR_SEQ_DIV_A    = 2'd1;
    localparam logic [1:0] FIR_SEQ_COUNT_A  = 2'd2;
    localparam logic [1:0] FIR_SEQ_STATUS_A = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START_B = 0;
    localparam int CTRL_STOP_B  = 1;
    localparam int CTRL_CONT_B  = 2;
    localparam int CTRL_IRQEN_B = 3;

    // STATUS bit positions; level occupies [ST_LVL_LSB+2:ST_LVL_LSB]
    localparam int ST_BUSY_B  = 0;
    localparam int ST_DONE_B  = 1;
    localparam int ST_OVF_B   = 2;
    localparam int ST_LVL_LSB = 4;

endpackage

// File: rtl/fir_seq_delay_line.sv
// Fixed-latency 1-bit delay line: q_o is d_i delayed by LAT cycles.
// Async reset clears every stage so nothing stale emerges after reset.
module fir_seq_delay_line #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [LAT-1:0] sh_q;

    // shift the strobe one stage per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q[0] <= d_i;
            for (int i = 1; i < LAT; i++) sh_q[i] <= sh_q[i-1];
        end
    end

    assign q_o = sh_q[LAT-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR-to-FIFO sequencer: AHB register slave, sample-strobe FSM,
// FIR-latency delay line and FIFO occupancy tracking.
// Optional FIR_SEQ_CTRL_LEVEL_EN: occupancy level, OVF flag and the
// STATUS level field; without it those read 0 and fifo_read is unused.
module fir_seq_ctrl
    import ahb_fir_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int AWIDTH     = 8,
    parameter int DIV_WIDTH  = 8,
    parameter int FIR_LAT    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic              hwrite,
    input  logic              hready,
    input  logic [AWIDTH-1:0] haddr,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic [DWIDTH-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DWIDTH-1:0] hrdata,
    output logic              fir_sample_en,
    output logic              fifo_write_en,
    input  logic              fifo_read,
    output logic              busy,
    output logic              irq
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W = $clog2(FIR_LAT + 1);

    fir_seq_state_t         state_q, state_d;
    logic                   act_q, wr_q;
    logic [1:0]             addr_q;
    logic                   cont_q, irq_en_q, done_q;
    logic [DIV_WIDTH-1:0]   div_q, div_cnt_q, div_cnt_d;
    logic [DWIDTH-1:0]      count_q, rem_q, rem_d;
    logic [LAT_W-1:0]       drn_q, drn_d;
    logic                   strobe, done_set;
    logic                   wr_en, wr_ctrl, wr_status, start_req, stop_req, cont_eff;
    logic                   ovf;
    logic [LVL_W-1:0]       level;
    logic [DWIDTH-1:0]      lvl_ext;

    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;
    assign busy      = (state_q != IDLE);

    // AHB address phase capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else if (hready) begin
            act_q  <= hsel & htrans[1];
            wr_q   <= hwrite;
            addr_q <= haddr[1:0];
        end
    end

    assign wr_en     = act_q & wr_q & hready;
    assign wr_ctrl   = wr_en && (addr_q == FIR_SEQ_CTRL_A);
    assign wr_status = wr_en && (addr_q == FIR_SEQ_STATUS_A);
    assign start_req = wr_ctrl & hwdata[CTRL_START_B];
    assign stop_req  = wr_ctrl & hwdata[CTRL_STOP_B];
    // a START written together with CONT sees the new CONT value
    assign cont_eff  = wr_ctrl ? hwdata[CTRL_CONT_B] : cont_q;

    // control/config registers; DIV and COUNT frozen while a run is active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q   <= 1'b0;
            irq_en_q <= 1'b0;
            div_q    <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ctrl) begin
                cont_q   <= hwdata[CTRL_CONT_B];
                irq_en_q <= hwdata[CTRL_IRQEN_B];
            end
            if (wr_en && addr_q == FIR_SEQ_DIV_A && !busy)   div_q   <= hwdata[DIV_WIDTH-1:0];
            if (wr_en && addr_q == FIR_SEQ_COUNT_A && !busy) count_q <= hwdata;
        end
    end

    // FSM and run counters: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            rem_q     <= '0;
            drn_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            rem_q     <= rem_d;
            drn_q     <= drn_d;
        end
    end

    // FSM next state, strobe generation and drain timing.
    // DONE is raised one cycle early so it is visible in the last DRAIN
    // cycle, the same cycle the final fifo_write_en leaves the delay line.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        rem_d     = rem_q;
        drn_d     = drn_q;
        strobe    = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req && (cont_eff || count_q != '0)) begin
                    state_d   = RUN;
                    div_cnt_d = div_q;
                    rem_d     = count_q;
                end
            end
            RUN: begin
                if (div_cnt_q == '0) begin
                    strobe    = 1'b1;
                    div_cnt_d = div_q;
                    if (!cont_q) begin
                        if (rem_q != '0) rem_d = rem_q - DWIDTH'(1);
                        if (rem_q <= DWIDTH'(1)) state_d = DRAIN;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
                end
                if (stop_req) state_d = DRAIN;
                if (state_d == DRAIN) begin
                    drn_d    = LAT_W'(FIR_LAT - 1);
                    done_set = (FIR_LAT == 1);
                end
            end
            DRAIN: begin
                if (drn_q == '0) state_d = IDLE;
                else drn_d = drn_q - LAT_W'(1);
                done_set = (drn_q == LAT_W'(1));
            end
            default: state_d = IDLE;
        endcase
    end

    assign fir_sample_en = strobe;

    fir_seq_delay_line #(.LAT(FIR_LAT)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (strobe),
        .q_o   (fifo_write_en)
    );

    // sticky DONE; a new completion wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                done_q <= 1'b0;
        else if (done_set)                         done_q <= 1'b1;
        else if (wr_status && hwdata[ST_DONE_B])   done_q <= 1'b0;
    end

`ifdef FIR_SEQ_CTRL_LEVEL_EN
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_set;

    // occupancy next-state: write beats read, full write overwrites oldest
    always_comb begin
        level_d = level_q;
        ovf_set = 1'b0;
        if (fifo_write_en) begin
            if (level_q == LVL_W'(FIFO_DEPTH)) ovf_set = 1'b1;
            else                               level_d = level_q + LVL_W'(1);
        end else if (fifo_read && level_q != '0) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            if (ovf_set)                              ovf_q <= 1'b1;
            else if (wr_status && hwdata[ST_OVF_B])   ovf_q <= 1'b0;
        end
    end

    assign level = level_q;
    assign ovf   = ovf_q;
`else
    assign level = '0;
    assign ovf   = 1'b0;
`endif

    assign irq     = irq_en_q & (done_q | ovf);
    assign lvl_ext = DWIDTH'(level);

    // combinational read data during a read data phase, else 0
    always_comb begin
        hrdata = '0;
        if (act_q && !wr_q) begin
            case (addr_q)
                FIR_SEQ_CTRL_A: begin
                    hrdata[CTRL_CONT_B]  = cont_q;
                    hrdata[CTRL_IRQEN_B] = irq_en_q;
                end
                FIR_SEQ_DIV_A:   hrdata = DWIDTH'(div_q);
                FIR_SEQ_COUNT_A: hrdata = count_q;
                default: begin
                    hrdata[ST_BUSY_B] = busy;
                    hrdata[ST_DONE_B] = done_q;
                    hrdata[ST_OVF_B]  = ovf;
                    hrdata[ST_LVL_LSB+2:ST_LVL_LSB] = lvl_ext[2:0];
                end
            endcase
        end
    end

    // inputs that are legitimately not decoded
    logic unused_ok;
    assign unused_ok = ^{hsize, htrans[0], haddr, hwdata, fifo_read};

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl (FIR_LAT=3, FIFO_DEPTH=4, DIV_WIDTH=8).
// Level/OVF expectations follow FIR_SEQ_CTRL_LEVEL_EN.
module tb_fir_seq_ctrl;
    import ahb_fir_pkg::*;

`ifdef FIR_SEQ_CTRL_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       hsel = 0, hwrite = 0, hready = 1, fifo_read = 0;
    logic [7:0] haddr = '0, hwdata = '0;
    logic [2:0] hsize = 3'd0;
    logic [1:0] htrans = 2'b00;
    logic       hreadyout, hresp, fir_sample_en, fifo_write_en, busy, irq;
    logic [7:0] hrdata;

    fir_seq_ctrl #(.DWIDTH(8), .AWIDTH(8), .DIV_WIDTH(8), .FIR_LAT(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .hsel(hsel), .hwrite(hwrite), .hready(hready),
        .haddr(haddr), .hsize(hsize), .htrans(htrans), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .fir_sample_en(fir_sample_en), .fifo_write_en(fifo_write_en),
        .fifo_read(fifo_read), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit mon_en = 0;
    int se_cnt = 0, we_cnt = 0;

    always @(negedge clk) if (mon_en) begin
        se_cnt += int'(fir_sample_en);
        we_cnt += int'(fifo_write_en);
    end

    typedef struct { logic [1:0] a; logic [7:0] wd; logic [7:0] rd; } reg_vec_t;
    typedef struct { logic se; logic we; logic bsy; logic irq; } cyc_t;
    reg_vec_t rv[8];
    cyc_t     bt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic ahb_wr(input logic [1:0] a, input logic [7:0] d);
        hsel = 1; hwrite = 1; htrans = 2'b10; haddr = {6'd0, a};
        step();
        hsel = 0; hwrite = 0; htrans = 2'b00; hwdata = d;
        step();
    endtask

    task automatic ahb_rd(input logic [1:0] a, output logic [7:0] d);
        hsel = 1; hwrite = 0; htrans = 2'b10; haddr = {6'd0, a};
        step();
        hsel = 0; htrans = 2'b00;
        d = hrdata;
        step();
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        ahb_rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic pulse_read();
        fifo_read = 1; step(); fifo_read = 0;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin step(); n++; end
        chk(nm, busy, 1'b0);
    endtask

    initial begin
        rv[0] = '{FIR_SEQ_DIV_A,    8'h5A, 8'h5A};
        rv[1] = '{FIR_SEQ_COUNT_A,  8'hC3, 8'hC3};
        rv[2] = '{FIR_SEQ_CTRL_A,   8'h0C, 8'h0C};
        rv[3] = '{FIR_SEQ_CTRL_A,   8'hF4, 8'h04};
        rv[4] = '{FIR_SEQ_DIV_A,    8'h00, 8'h00};
        rv[5] = '{FIR_SEQ_COUNT_A,  8'h00, 8'h00};
        rv[6] = '{FIR_SEQ_CTRL_A,   8'h00, 8'h00};
        rv[7] = '{FIR_SEQ_STATUS_A, 8'h06, 8'h00};
        // DIV=2 COUNT=3: strobes t0+2/5/8, writes t0+5/8/11, DONE(irq) at t0+11
        for (int k = 0; k < 14; k++) begin
            bt[k].se  = (k == 2 || k == 5 || k == 8);
            bt[k].we  = (k == 5 || k == 8 || k == 11);
            bt[k].bsy = (k <= 11);
            bt[k].irq = (k >= 11);
        end

        // reset state
        repeat (2) step();
        chk("rst hreadyout", hreadyout, 1'b1);
        chk("rst hresp", hresp, 1'b0);
        chk("rst outputs", {hrdata, fir_sample_en, fifo_write_en, busy, irq}, '0);
        rst_n = 1;
        step();
        rd_chk("rst CTRL", FIR_SEQ_CTRL_A, 8'h00);
        rd_chk("rst DIV", FIR_SEQ_DIV_A, 8'h00);
        rd_chk("rst STATUS", FIR_SEQ_STATUS_A, 8'h00);
        chk("idle hrdata", hrdata, 8'h00);

        // register write/readback table
        for (int i = 0; i < 8; i++) begin
            ahb_wr(rv[i].a, rv[i].wd);
            rd_chk($sformatf("reg vec %0d", i), rv[i].a, rv[i].rd);
        end

        // START with CONT=0 and COUNT=0 is ignored
        ahb_wr(FIR_SEQ_CTRL_A, 8'h01);
        chk("ign start busy0", busy, 1'b0);
        step();
        chk("ign start busy1", busy, 1'b0);
        chk("ign start se", fir_sample_en, 1'b0);

        // burst DIV=2 COUNT=3 with IRQ_EN, per-cycle table
        ahb_wr(FIR_SEQ_DIV_A, 8'd2);
        ahb_wr(FIR_SEQ_COUNT_A, 8'd3);
        ahb_wr(FIR_SEQ_CTRL_A, 8'h08);
        ahb_wr(FIR_SEQ_CTRL_A, 8'h09);
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("burst se t%0d", k), fir_sample_en, bt[k].se);
            chk($sformatf("burst we t%0d", k), fifo_write_en, bt[k].we);
            chk($sformatf("burst busy t%0d", k), busy, bt[k].bsy);
            chk($sformatf("burst irq t%0d", k), irq, bt[k].irq);
            step();
        end
        rd_chk("burst STATUS", FIR_SEQ_STATUS_A, LVL ? 8'h32 : 8'h02);
        ahb_wr(FIR_SEQ_STATUS_A, 8'h02);
        chk("done clr irq", irq, 1'b0);

        // coincident read and write: level 2 -> 3
        pulse_read();
        ahb_wr(FIR_SEQ_DIV_A, 8'd0);
        ahb_wr(FIR_SEQ_COUNT_A, 8'd1);
        ahb_wr(FIR_SEQ_CTRL_A, 8'h09);
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                chk("coinc we", fifo_write_en, 1'b1);
                fifo_read = 1;
            end
            if (k == 4) fifo_read = 0;
            step();
        end
        rd_chk("coinc STATUS", FIR_SEQ_STATUS_A, LVL ? 8'h32 : 8'h02);
        ahb_wr(FIR_SEQ_STATUS_A, 8'h02);
        repeat (4) pulse_read();
        rd_chk("empty read STATUS", FIR_SEQ_STATUS_A, 8'h00);

        // continuous mode, DIV write while busy, STOP after 5 strobes
        se_cnt = 0; we_cnt = 0; mon_en = 1;
        ahb_wr(FIR_SEQ_CTRL_A, 8'h04);
        ahb_wr(FIR_SEQ_CTRL_A, 8'h05);
        ahb_wr(FIR_SEQ_DIV_A, 8'h07);
        step();
        ahb_wr(FIR_SEQ_CTRL_A, 8'h06);
        wait_idle("cont idle", 40);
        repeat (3) step();
        mon_en = 0;
        chk("cont strobes", se_cnt, 5);
        chk("cont writes", we_cnt, 5);
        rd_chk("div while busy", FIR_SEQ_DIV_A, 8'h00);
        rd_chk("cont STATUS", FIR_SEQ_STATUS_A, LVL ? 8'h46 : 8'h02);
        chk("cont irq gated", irq, 1'b0);
        ahb_wr(FIR_SEQ_CTRL_A, 8'h08);
        chk("cont irq en", irq, 1'b1);
        ahb_wr(FIR_SEQ_STATUS_A, 8'h02);
        chk("ovf irq", irq, LVL);
        ahb_wr(FIR_SEQ_STATUS_A, 8'h04);
        chk("ovf clr irq", irq, 1'b0);
        rd_chk("ovf clr STATUS", FIR_SEQ_STATUS_A, LVL ? 8'h40 : 8'h00);
        repeat (5) pulse_read();

        // overflow: COUNT=6, no reads
        ahb_wr(FIR_SEQ_DIV_A, 8'd1);
        ahb_wr(FIR_SEQ_COUNT_A, 8'd6);
        ahb_wr(FIR_SEQ_CTRL_A, 8'h09);
        wait_idle("ovf idle", 60);
        rd_chk("ovf STATUS", FIR_SEQ_STATUS_A, LVL ? 8'h46 : 8'h02);
        chk("ovf irq set", irq, 1'b1);
        ahb_wr(FIR_SEQ_STATUS_A, 8'h04);
        rd_chk("ovf w1c STATUS", FIR_SEQ_STATUS_A, LVL ? 8'h42 : 8'h02);
        ahb_wr(FIR_SEQ_STATUS_A, 8'h02);
        chk("all clr irq", irq, 1'b0);

        // reset mid-burst
        ahb_wr(FIR_SEQ_DIV_A, 8'd0);
        ahb_wr(FIR_SEQ_COUNT_A, 8'd8);
        ahb_wr(FIR_SEQ_CTRL_A, 8'h09);
        repeat (3) step();
        chk("mid busy", busy, 1'b1);
        chk("mid se", fir_sample_en, 1'b1);
        rst_n = 0;
        #1;
        chk("mid rst outputs", {hrdata, fir_sample_en, fifo_write_en, busy, irq}, '0);
        step();
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("post rst we %0d", k), fifo_write_en, 1'b0);
            chk($sformatf("post rst busy %0d", k), busy, 1'b0);
            step();
        end
        rd_chk("post rst STATUS", FIR_SEQ_STATUS_A, 8'h00);
        rd_chk("post rst COUNT", FIR_SEQ_COUNT_A, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

AHB-programmable sequencer for the FIR-to-FIFO sample path. It generates the sample strobe that paces the FIR filter and delays that strobe by the FIR pipeline latency to produce the FIFO write enable. It tracks FIFO occupancy from the write and read strobes and raises a done/overflow interrupt. It sits beside the output FIFO on the same AHB bus, as a separate zero-wait-state slave.

## Interface
- DWIDTH, 8: AHB data width; register width.
- DIV_WIDTH, 8: width of the sample-period divider; must be ≤ DWIDTH.
- FIR_LAT, 3: cycles from fir_sample_en to a valid FIR output; must be ≥ 1.
- FIFO_DEPTH, 4: depth of the output FIFO; must be a power of two.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hsel, hwrite, hready  in  1  AHB select, write and ready.
- haddr  in  AWIDTH  AHB address; only bits [1:0] are decoded.
- hsize  in  3  AHB transfer size; ignored.
- htrans  in  2  AHB transfer type.
- hwdata  in  DWIDTH  AHB write data.
- hreadyout  out  1  constant 1.
- hresp  out  1  constant 0.
- hrdata  out  DWIDTH  AHB read data.
- fir_sample_en  out  1  one-cycle strobe: the FIR takes a new input sample.
- fifo_write_en  out  1  one-cycle strobe: push FIR output into the FIFO.
- fifo_read  in  1  one-cycle pulse per FIFO pop, taken from the FIFO's read strobe.
- busy  out  1  high whenever the FSM is not IDLE.
- irq  out  1  level-sensitive interrupt.

## Operation
- AHB address phase is registered when hready=1. A transfer is active in the data phase when htrans[1]=1 and hsel=1.
- Writes take effect at the clock edge ending the data phase.
- Reads return data combinationally during the data phase. hrdata is 0 when there is no active read.
- Register map:
  - 0 CTRL:
    - bit0 START: write 1; self-clearing; reads 0.
    - bit1 STOP: write 1; self-clearing; reads 0.
    - bit2 CONT: continuous mode.
    - bit3 IRQ_EN.
  - 1 DIV: sample period minus 1.
  - 2 COUNT: number of samples per burst.
  - 3 STATUS:
    - bit0 busy.
    - bit1 DONE: sticky; write 1 to clear.
    - bit2 OVF: sticky; write 1 to clear.
    - bits[6:4] level; bits wider than the level width read 0.
- Writes to DIV and COUNT are ignored while busy. CTRL bits 2 and 3 are always writable.
- FSM states IDLE, RUN, DRAIN:
  - IDLE→RUN on START when CONT=1 or COUNT≠0. At entry, the divider loads DIV and the remaining counter loads COUNT.
  - START with CONT=0 and COUNT=0 is ignored.
  - In RUN, fir_sample_en is asserted when the divider reaches 0; the divider then reloads DIV.
  - In RUN with CONT=0, each strobe decrements the remaining counter. The strobe that takes it to 0 moves the FSM to DRAIN on the next cycle.
  - STOP in RUN→DRAIN. No further strobes are issued; a strobe in the same cycle as STOP is still issued.
  - DRAIN counts FIR_LAT cycles, then DONE is set and the FSM returns to IDLE.
  - START while busy is ignored. STOP in IDLE or DRAIN is ignored.
- fifo_write_en is fir_sample_en delayed by exactly FIR_LAT cycles through a shift register.
- Occupancy level, modelling FIFO behaviour:
  - Write has priority over read. Write and read in the same cycle → +1; the read is ignored.
  - Write when level=FIFO_DEPTH → level unchanged and OVF set, because the FIFO overwrites its oldest entry.
  - Read alone → −1; read when empty → 0.
- irq = IRQ_EN & (DONE | OVF).

## Timing
- Reset values:
  - All outputs 0 except hreadyout=1.
  - FSM in IDLE.
  - All registers, counters, level and delay line cleared.
- Sample strobes:
  - First fir_sample_en occurs DIV cycles after the first RUN cycle (the same cycle if DIV=0).
  - Strobe period is DIV+1 cycles; DIV=0 gives a strobe every cycle.
- DONE is set in the same cycle as the last fifo_write_en. busy falls on the following cycle.
- Counters wrap only by reload. The remaining counter never underflows.
- Reset asserted mid-burst aborts immediately and flushes the delay line; no stale fifo_write_en appears after reset release.

## Configuration
- Macro FIR_SEQ_CTRL_LEVEL_EN.
- Defined: occupancy counter, OVF flag and the level field are present.
- Undefined: STATUS bits [6:4] and bit2 read 0, OVF never sets, irq = IRQ_EN & DONE, and fifo_read is ignored.

## Structure
- Extend ahb_fir_pkg with:
  - typedef enum fir_seq_state_t {IDLE, RUN, DRAIN}.
  - Register address constants FIR_SEQ_CTRL_A, FIR_SEQ_DIV_A, FIR_SEQ_COUNT_A, FIR_SEQ_STATUS_A.
  - CTRL and STATUS bit-index constants.
- One sub-module, fir_seq_delay_line, holds the FIR_LAT-deep 1-bit shift register with async reset.

## Test plan
- Burst:
  - Stimulus: DIV=2, COUNT=3, FIR_LAT=3, write START; first RUN cycle is t0.
  - Response: fir_sample_en at t0+2, t0+5, t0+8; fifo_write_en at t0+5, t0+8, t0+11; DONE set at t0+11; busy low at t0+12.
- Continuous mode and STOP:
  - Stimulus: DIV=0, CONT=1, START, STOP after 5 strobes.
  - Response: 5 or 6 strobes, exactly matching fifo_write_en count, then IDLE with DONE=1.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, burst COUNT=6, no reads.
  - Response: level saturates at 4, OVF=1, irq=1 when IRQ_EN=1. Writing STATUS=0x04 clears OVF.
- Simultaneous read and write:
  - Stimulus: level 2, fifo_read coincident with fifo_write_en.
  - Response: level becomes 3. A later read when level=0 leaves 0.
- Ignored writes:
  - Stimulus: COUNT=0 with CONT=0 then START; DIV written while busy.
  - Response: START has no effect; DIV readback is unchanged.
- Reset mid-burst:
  - Stimulus: rst_n low for one cycle during RUN.
  - Response: all outputs 0; no fifo_write_en within FIR_LAT cycles after release.
